// File: rtl/interrupt_ack_sequencer_8259a_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_ack_sequencer_8259a_pkg
// Brief    : Shared state encoding, OCW2 command codes and priority helpers
//            for the 8259A acknowledge sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_ack_sequencer_8259a_pkg;

    // Acknowledge handshake states (8086 mode, two INTA pulses)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } ack_state_t;

    // OCW2 {R, SL, EOI} command codes
    localparam logic [2:0] c_ocw2_clr_rot_aeoi = 3'b000;
    localparam logic [2:0] c_ocw2_ns_eoi       = 3'b001;
    localparam logic [2:0] c_ocw2_nop          = 3'b010;
    localparam logic [2:0] c_ocw2_s_eoi        = 3'b011;
    localparam logic [2:0] c_ocw2_set_rot_aeoi = 3'b100;
    localparam logic [2:0] c_ocw2_rot_ns_eoi   = 3'b101;
    localparam logic [2:0] c_ocw2_set_priority = 3'b110;
    localparam logic [2:0] c_ocw2_rot_s_eoi    = 3'b111;

    // One-hot to binary level number
    function automatic logic [2:0] encode_onehot(input logic [7:0] src);
        logic [2:0] result;
        result = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (src[i]) result = result | 3'(i);
        end
        return result;
    endfunction

    // Circular right rotate of an 8-bit vector
    function automatic logic [7:0] rotate_right(input logic [7:0] src, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {src, src} >> amount;
        return doubled[7:0];
    endfunction

    // Circular left rotate of an 8-bit vector
    function automatic logic [7:0] rotate_left(input logic [7:0] src, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {src, src} << amount;
        return doubled[15:8];
    endfunction

    // Keep only the lowest-numbered set bit (bit 0 = highest priority)
    function automatic logic [7:0] resolv_priority(input logic [7:0] src);
        return src & (~src + 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_ack_sequencer_8259a_in_service_priority_finder.sv
`default_nettype none
// ============================================================================
// Module   : in_service_priority_finder
// Brief    : Picks the highest-priority in-service level under the current
//            rotation; priority runs from rotate+1 (highest) to rotate.
// Revision : 1.0 - initial release
// ============================================================================
module in_service_priority_finder (
    input  logic [7:0] in_service_register,
    input  logic [2:0] priority_rotate,
    output logic [7:0] highest_level_in_service
);
    import interrupt_ack_sequencer_8259a_pkg::*;

    logic [2:0] w_shift;

    // Rotate so the highest-priority level lands on bit 0, isolate, rotate back
    assign w_shift = priority_rotate + 3'd1;
    assign highest_level_in_service =
        rotate_left(resolv_priority(rotate_right(in_service_register, w_shift)), w_shift);

endmodule
`default_nettype wire

// File: rtl/interrupt_ack_sequencer_8259a.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_ack_sequencer_8259a
// Brief    : IRR/ISR ownership, INT generation, two-pulse INTA handshake and
//            OCW2 end-of-interrupt / rotation handling for the 8259A core.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_ack_sequencer_8259a #(
    parameter int VECTOR_BASE_WIDTH = 5
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [7:0]                   ir_pins,
    input  logic                         level_or_edge_triggered,
    input  logic                         auto_eoi_config,
    input  logic [VECTOR_BASE_WIDTH-1:0] vector_base,
    input  logic                         inta_n,
    input  logic [7:0]                   resolved_interrupt,
    input  logic                         ocw2_valid,
    input  logic [2:0]                   ocw2_command,
    input  logic [2:0]                   ocw2_level,
    output logic [7:0]                   interrupt_request_register,
    output logic [7:0]                   in_service_register,
    output logic [7:0]                   highest_level_in_service,
    output logic [2:0]                   priority_rotate,
    output logic                         int_out,
    output logic [7:0]                   data_out,
    output logic                         data_out_enable
);
    import interrupt_ack_sequencer_8259a_pkg::*;

    ack_state_t r_state;
    logic       r_inta_prev;
    logic [7:0] r_ir_sync;
    logic [7:0] r_ir_prev;
    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [7:0] r_ack_level;
    logic [2:0] r_rotate;
    logic       r_rot_aeoi;
    logic       r_spurious;
    logic       r_int;
    logic [7:0] r_data;
    logic       r_doe;

    logic       w_inta_fall;
    logic       w_inta_rise;
    logic       w_ack1_entry;
    logic       w_ack2_exit;
    logic [7:0] w_hlis;
    logic [7:0] w_isr_set;
    logic [7:0] w_aeoi_clr;
    logic [7:0] w_ocw2_clr;
    logic [7:0] w_irr_next;
    logic [2:0] w_rotate_next;
    logic       w_rot_aeoi_next;

    in_service_priority_finder u_isr_finder (
        .in_service_register      (r_isr),
        .priority_rotate          (r_rotate),
        .highest_level_in_service (w_hlis)
    );

    assign w_inta_fall  = r_inta_prev & ~inta_n;
    assign w_inta_rise  = ~r_inta_prev & inta_n;
    assign w_ack1_entry = (r_state == ST_IDLE) && w_inta_fall;
    assign w_ack2_exit  = (r_state == ST_ACK2) && w_inta_rise;

    // A spurious acknowledge has an all-zero candidate, so it sets and clears nothing
    assign w_isr_set  = w_ack1_entry ? resolved_interrupt : 8'h00;
    assign w_aeoi_clr = (w_ack2_exit && auto_eoi_config && !r_spurious) ? r_ack_level : 8'h00;

    // Edge mode needs a fresh rise to set and the pin held high to keep the request
    assign w_irr_next = level_or_edge_triggered
                      ? (r_ir_sync & ~w_isr_set)
                      : (((r_irr | (r_ir_sync & ~r_ir_prev)) & r_ir_sync) & ~w_isr_set);

    // OCW2 decode; AEOI rotation is applied first so an OCW2 rotate overrides it
    always_comb begin
        w_ocw2_clr      = 8'h00;
        w_rotate_next   = r_rotate;
        w_rot_aeoi_next = r_rot_aeoi;
        if (w_ack2_exit && auto_eoi_config && !r_spurious && r_rot_aeoi) begin
            w_rotate_next = encode_onehot(r_ack_level);
        end
        if (ocw2_valid) begin
            case (ocw2_command)
                c_ocw2_clr_rot_aeoi: w_rot_aeoi_next = 1'b0;
                c_ocw2_ns_eoi:       w_ocw2_clr = w_hlis;
                c_ocw2_nop:          ;
                c_ocw2_s_eoi:        w_ocw2_clr = 8'd1 << ocw2_level;
                c_ocw2_set_rot_aeoi: w_rot_aeoi_next = 1'b1;
                c_ocw2_rot_ns_eoi: begin
                    if (|r_isr) begin
                        w_ocw2_clr    = w_hlis;
                        w_rotate_next = encode_onehot(w_hlis);
                    end
                end
                c_ocw2_set_priority: w_rotate_next = ocw2_level;
                c_ocw2_rot_s_eoi: begin
                    w_ocw2_clr    = 8'd1 << ocw2_level;
                    w_rotate_next = ocw2_level;
                end
                default: ;
            endcase
        end
    end

    // Request/service registers, rotation and input history; ack set beats any clear
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_inta_prev <= 1'b1;
            r_ir_sync   <= 8'h00;
            r_ir_prev   <= 8'h00;
            r_irr       <= 8'h00;
            r_isr       <= 8'h00;
            r_rotate    <= 3'b111;
            r_rot_aeoi  <= 1'b0;
        end else begin
            r_inta_prev <= inta_n;
            r_ir_sync   <= ir_pins;
            r_ir_prev   <= r_ir_sync;
            r_irr       <= w_irr_next;
            r_isr       <= (r_isr & ~(w_ocw2_clr | w_aeoi_clr)) | w_isr_set;
            r_rotate    <= w_rotate_next;
            r_rot_aeoi  <= w_rot_aeoi_next;
        end
    end

    // INTA handshake sequencer with registered INT and vector bus outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ack_level <= 8'h80;
            r_spurious  <= 1'b0;
            r_int       <= 1'b0;
            r_data      <= 8'h00;
            r_doe       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_inta_fall) begin
                        r_state <= ST_ACK1;
                        r_int   <= 1'b0;
                        if (resolved_interrupt == 8'h00) begin
                            r_ack_level <= 8'h80;
                            r_spurious  <= 1'b1;
                        end else begin
                            r_ack_level <= resolved_interrupt;
                            r_spurious  <= 1'b0;
                        end
                    end else if (|resolved_interrupt) begin
                        r_int <= 1'b1;
                    end
                end
                ST_ACK1: begin
                    if (w_inta_rise) r_state <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (w_inta_fall) begin
                        r_state <= ST_ACK2;
                        r_data  <= {vector_base, encode_onehot(r_ack_level)};
                        r_doe   <= 1'b1;
                    end
                end
                ST_ACK2: begin
                    if (w_inta_rise) begin
                        r_state <= ST_IDLE;
                        r_doe   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign interrupt_request_register = r_irr;
    assign in_service_register        = r_isr;
    assign highest_level_in_service   = w_hlis;
    assign priority_rotate            = r_rotate;
    assign int_out                    = r_int;
    assign data_out                   = r_data;
    assign data_out_enable            = r_doe;

endmodule
`default_nettype wire
